// File: rtl/au_lead_sign_norm_pkg.sv
// Shared types and helpers for the au_lead_sign_norm pipeline.
// The result struct is sized for the widest legal word; users slice the low bits.
package au_lead_sign_norm_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MIN_TAG_W = 1;
  localparam int MAX_WIDTH = 64;
  localparam int MAX_CNT_W = 7;

  // Width of a shift count that can represent 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  typedef struct packed {
    logic [MAX_WIDTH-1:0] onehot;
    logic [MAX_CNT_W-1:0] cnt;
    logic                 flag;
  } lsn_res_t;

endpackage

// File: rtl/au_lead_sign_norm_if.sv
// Streaming in/out bundle for au_lead_sign_norm.
// slave = the normalizer, master = the producer/consumer side.
interface au_lead_sign_norm_if
  import au_lead_sign_norm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) ();
  localparam int CW = cnt_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_tc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_onehot;
  logic [CW-1:0]    out_cnt;
  logic [WIDTH-1:0] out_norm;
  logic             out_flag;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_data, in_tc, in_tag, out_ready,
    output in_ready, out_valid, out_onehot, out_cnt, out_norm, out_flag, out_tag
  );

  modport master (
    output in_valid, in_data, in_tc, in_tag, out_ready,
    input  in_ready, out_valid, out_onehot, out_cnt, out_norm, out_flag, out_tag
  );
endinterface

// File: rtl/au_lead_sign_norm_enc.sv
// Combinational leading-sign / leading-zero detect and encode.
// Signed: position of the lowest bit of the leading sign run. Unsigned: first 1.
module au_lead_sign_enc
  import au_lead_sign_norm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic             tc,
  output lsn_res_t         res
);
  localparam int CW = cnt_w(WIDTH);

  logic [CW-1:0] pos;
  logic          found;

  // Scan low to high so the last hit (highest index) wins.
  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      if (tc && (data[i] != data[i-1])) begin
        pos   = CW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (!tc && data[i]) begin
        pos   = CW'(i);
        found = 1'b1;
      end
    end
    res = '0;
    if (found) begin
      res.onehot = MAX_WIDTH'(1) << pos;
      res.cnt    = MAX_CNT_W'(CW'(WIDTH - 1) - pos);
    end else if (tc) begin
      // All bits equal: the sign run covers the word, park at bit 0.
      res.onehot = MAX_WIDTH'(1);
      res.cnt    = MAX_CNT_W'(WIDTH - 1);
      res.flag   = 1'b1;
    end else begin
      // Zero word: no position, shift everything out.
      res.cnt  = MAX_CNT_W'(WIDTH);
      res.flag = 1'b1;
    end
  end
endmodule

// File: rtl/au_lead_sign_norm.sv
// Two-stage leading-sign normalizer with valid/ready backpressure.
// S1: encode; S2: optional barrel shift. Optional shifter: AU_LEAD_SIGN_NORM_SHIFT_EN.
module au_lead_sign_norm
  import au_lead_sign_norm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  au_lead_sign_norm_if.slave  bus
);
  localparam int CW = cnt_w(WIDTH);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || TAG_W < MIN_TAG_W || CW > MAX_CNT_W) begin : g_bad_param
    $fatal(1, "au_lead_sign_norm: illegal WIDTH=%0d / TAG_W=%0d", WIDTH, TAG_W);
  end

  lsn_res_t         enc_res;
  logic             unused_res;
  logic             in_ready, s1_load, s2_load;
  logic             s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic [WIDTH-1:0] s1_data_d, s1_data_q;
  logic [WIDTH-1:0] s1_oh_d, s1_oh_q, s2_oh_d, s2_oh_q;
  logic [CW-1:0]    s1_cnt_d, s1_cnt_q, s2_cnt_d, s2_cnt_q;
  logic             s1_flag_d, s1_flag_q, s2_flag_d, s2_flag_q;
  logic [TAG_W-1:0] s1_tag_d, s1_tag_q, s2_tag_d, s2_tag_q;

  au_lead_sign_enc #(.WIDTH(WIDTH)) u_enc (
    .data (bus.in_data),
    .tc   (bus.in_tc),
    .res  (enc_res)
  );
  assign unused_res = ^enc_res;

  // Handshake and stage advance; a stage loads when empty or draining this cycle.
  always_comb begin
    in_ready   = !s1_valid_q || !s2_valid_q || bus.out_ready;
    s1_load    = bus.in_valid && in_ready;
    s2_load    = s1_valid_q && (!s2_valid_q || bus.out_ready);
    s1_valid_d = s1_load || (s1_valid_q && !s2_load);
    s2_valid_d = s2_load || (s2_valid_q && !bus.out_ready);
    s1_data_d  = s1_data_q;
    s1_oh_d    = s1_oh_q;
    s1_cnt_d   = s1_cnt_q;
    s1_flag_d  = s1_flag_q;
    s1_tag_d   = s1_tag_q;
    s2_oh_d    = s2_oh_q;
    s2_cnt_d   = s2_cnt_q;
    s2_flag_d  = s2_flag_q;
    s2_tag_d   = s2_tag_q;
    if (s1_load) begin
      s1_data_d = bus.in_data;
      s1_oh_d   = enc_res.onehot[WIDTH-1:0];
      s1_cnt_d  = enc_res.cnt[CW-1:0];
      s1_flag_d = enc_res.flag;
      s1_tag_d  = bus.in_tag;
    end
    if (s2_load) begin
      s2_oh_d   = s1_oh_q;
      s2_cnt_d  = s1_cnt_q;
      s2_flag_d = s1_flag_q;
      s2_tag_d  = s1_tag_q;
    end
  end

  // Pipeline registers; reset drops any in-flight words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_oh_q    <= '0;
      s1_cnt_q   <= '0;
      s1_flag_q  <= 1'b0;
      s1_tag_q   <= '0;
      s2_oh_q    <= '0;
      s2_cnt_q   <= '0;
      s2_flag_q  <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_data_q  <= s1_data_d;
      s1_oh_q    <= s1_oh_d;
      s1_cnt_q   <= s1_cnt_d;
      s1_flag_q  <= s1_flag_d;
      s1_tag_q   <= s1_tag_d;
      s2_oh_q    <= s2_oh_d;
      s2_cnt_q   <= s2_cnt_d;
      s2_flag_q  <= s2_flag_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

`ifdef AU_LEAD_SIGN_NORM_SHIFT_EN
  logic [WIDTH-1:0] s2_norm_d, s2_norm_q;

  // Barrel shift in S2; a count of WIDTH shifts everything out.
  always_comb begin
    s2_norm_d = s2_norm_q;
    if (s2_load) s2_norm_d = s1_data_q << s1_cnt_q;
  end

  // Normalized value register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_norm_q <= '0;
    else        s2_norm_q <= s2_norm_d;
  end

  assign bus.out_norm = s2_norm_q;
`else
  logic unused_data;
  assign unused_data  = ^s1_data_q;
  assign bus.out_norm = '0;
`endif

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_onehot = s2_oh_q;
  assign bus.out_cnt    = s2_cnt_q;
  assign bus.out_flag   = s2_flag_q;
  assign bus.out_tag    = s2_tag_q;
endmodule

// File: tb/tb_au_lead_sign_norm.sv
// Randomized + directed bench for au_lead_sign_norm against a leading-run-count model.
module tb_au_lead_sign_norm;
  import au_lead_sign_norm_pkg::*;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int CW = cnt_w(W);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  au_lead_sign_norm_if #(.WIDTH(W), .TAG_W(TW)) bus ();
  au_lead_sign_norm #(.WIDTH(W), .TAG_W(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0]  oh;
    logic [CW-1:0] cnt;
    logic [W-1:0]  norm;
    logic          flag;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_pop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count the leading run from the MSB and derive everything from it.
  function automatic exp_t model(input logic [W-1:0] d, input logic tc, input logic [TW-1:0] tag);
    exp_t e;
    int   n = 0;
    if (tc) begin
      while (n < W && d[W-1-n] == d[W-1]) n++;
      e.cnt  = CW'(n - 1);
      e.flag = (n == W);
      e.oh   = W'(1) << (W - n);
    end else begin
      while (n < W && d[W-1-n] == 1'b0) n++;
      e.cnt  = CW'(n);
      e.flag = (n == W);
      e.oh   = (n == W) ? '0 : W'(1) << (W - 1 - n);
    end
`ifdef AU_LEAD_SIGN_NORM_SHIFT_EN
    e.norm = W'(d << n_shift(tc, n));
`else
    e.norm = '0;
`endif
    e.tag = tag;
    return e;
  endfunction

  function automatic int n_shift(input logic tc, input int n);
    return tc ? n - 1 : n;
  endfunction

  // One cycle: drive at negedge, check handshake and any presented result.
  task automatic step(input logic v, input logic [W-1:0] d, input logic tc,
                      input logic [TW-1:0] tag, input logic ordy, output logic acc);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_tc     = tc;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    #1;
    chk("in_ready", bus.in_ready, (exp_q.size() < 2) || ordy);
    if (bus.out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", bus.out_valid, 0);
      else begin
        chk("onehot", bus.out_onehot, exp_q[0].oh);
        chk("cnt",    bus.out_cnt,    exp_q[0].cnt);
        chk("norm",   bus.out_norm,   exp_q[0].norm);
        chk("flag",   bus.out_flag,   exp_q[0].flag);
        chk("tag",    bus.out_tag,    exp_q[0].tag);
        if (ordy) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
    acc = v && bus.in_ready;
    if (acc) exp_q.push_back(model(d, tc, tag));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid",  bus.out_valid,  0);
    chk("rst_ready",  bus.in_ready,   1);
    chk("rst_onehot", bus.out_onehot, 0);
    chk("rst_cnt",    bus.out_cnt,    0);
    chk("rst_norm",   bus.out_norm,   0);
    chk("rst_flag",   bus.out_flag,   0);
    chk("rst_tag",    bus.out_tag,    0);
  endtask

  // Single word on an idle pipe: invisible after 1 cycle, presented after 2.
  task automatic latency_word(input logic [W-1:0] d, input logic tc, input logic [TW-1:0] tag);
    logic acc;
    step(1'b1, d, tc, tag, 1'b1, acc);
    chk("lat_accept", acc, 1);
    step(1'b0, '0, 1'b0, '0, 1'b1, acc);
    chk("lat1_valid", bus.out_valid, 0);
    step(1'b0, '0, 1'b0, '0, 1'b1, acc);
    chk("lat2_valid", bus.out_valid, 1);
  endtask

  logic [W-1:0] dv [6] = '{8'h1F, 8'hFF, 8'h80, 8'h00, 8'h01, 8'h40};
  logic         tv [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic acc;
    int   next_tag;
    int   pop0;
    logic saw_stall;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_tc = 1'b0; bus.in_tag = '0;
    bus.out_ready = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors including the boundary words.
    for (int i = 0; i < 6; i++) latency_word(dv[i], tv[i], TW'(i + 1));

    // Backpressure: tags 1..5, consumer stalled on cycles 3-5.
    next_tag  = 1;
    saw_stall = 1'b0;
    pop0      = n_pop;
    for (int c = 1; c <= 14; c++) begin
      step(next_tag <= 5, W'($urandom), 1'($urandom), TW'(next_tag), !(c >= 3 && c <= 5), acc);
      if (next_tag <= 5 && !acc) saw_stall = 1'b1;
      if (acc) next_tag++;
    end
    chk("bp_stall_seen", saw_stall, 1);
    chk("bp_all_out", n_pop - pop0, 5);
    chk("bp_empty", exp_q.size(), 0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 600; c++)
      step(1'($urandom), W'($urandom), 1'($urandom), TW'($urandom),
           $urandom_range(0, 9) < 7, acc);
    for (int c = 0; c < 8; c++) step(1'b0, '0, 1'b0, '0, 1'b1, acc);
    chk("rand_drained", exp_q.size(), 0);

    // Reset with two words in flight.
    step(1'b1, 8'h3C, 1'b0, 4'hA, 1'b0, acc);
    step(1'b1, 8'hC3, 1'b1, 4'hB, 1'b0, acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    latency_word(8'hF0, 1'b1, 4'h7);
    step(1'b0, '0, 1'b0, '0, 1'b1, acc);
    chk("post_rst_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/au_lead_sign_norm.md
# au_lead_sign_norm

Pipelined leading-sign / leading-zero detector and normalizer with valid/ready streaming handshake.
- Per accepted word it produces the one-hot sign position, the binary shift count and the left-normalized value.
- Signed or unsigned interpretation is selected per word.
- Sits in the arithmetic-unit library in front of floating-point packers and block-floating-point scalers, replacing the purely combinational leading-sign detector where timing requires registered stages and backpressure.

## Interface
- WIDTH, 16: data word length (>= 2)
- TAG_W, 4: sideband tag width carried alongside each word (>= 1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block can accept input this cycle
- in_data  in  WIDTH  word to analyse
- in_tc  in  1  1 = two's-complement (leading signs), 0 = unsigned (leading zeros)
- in_tag  in  TAG_W  opaque sideband, returned unchanged
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_onehot  out  WIDTH  one-hot position p of least significant leading-sign bit (unsigned: first 1)
- out_cnt  out  $clog2(WIDTH+1)  normalization shift count
- out_norm  out  WIDTH  in_data << out_cnt (zero-filled)
- out_flag  out  1  signed: all bits equal; unsigned: in_data == 0
- out_tag  out  TAG_W  tag of this result

## Operation
- Signed (in_tc=1): p = highest i in [WIDTH-1..1] with a[i] != a[i-1]; none -> p = 0, out_flag = 1. out_cnt = WIDTH-1-p.
- Unsigned (in_tc=0): p = index of highest set bit, out_cnt = WIDTH-1-p; a == 0 -> out_onehot = 0, out_cnt = WIDTH, out_norm = 0, out_flag = 1.
- Exactly one bit of out_onehot is set except the unsigned-zero case.
- Two register stages: S1 captures in_data, in_tc, in_tag, and the computed onehot/cnt/flag. S2 captures the S1 fields plus the shifted value.
- Each stage holds a valid bit. A stage loads when it is empty or its downstream stage is unloading in the same cycle.
- in_ready = !s1_valid || !s2_valid || out_ready (combinational, no dependence on in_valid).
- out_* driven directly from S2 registers.

## Timing
- Latency 2 cycles from accepted input (in_valid && in_ready) to out_valid, when unstalled. Throughput 1 word/cycle.
- Transfers occur only on in_valid && in_ready, or on out_valid && out_ready.
- While out_valid && !out_ready, all out_* hold stable.
- With both stages full and out_ready low, in_ready = 0. No word is dropped or duplicated.
- Simultaneous S2 unload and S1 load in one cycle is permitted and keeps full rate.
- Reset (asynchronous, any time, including mid-stream): both valid bits clear immediately; in_ready = 1 after reset; out_valid = 0; out_onehot, out_cnt, out_norm, out_flag, out_tag all 0. In-flight words are discarded.
- Inputs are sampled only on accept; in_data may change freely otherwise.

## Configuration
- AU_LEAD_SIGN_NORM_SHIFT_EN defined: the S2 barrel shifter is present and out_norm = data << cnt.
- Not defined: the shifter and the S2 data register are omitted, and out_norm is tied to 0. All other outputs, latency and handshake are unchanged.

## Structure
- The package holds:
  - the count-width function clog2(WIDTH+1);
  - the parameter legality limits (WIDTH >= 2, TAG_W >= 1), checked at elaboration with an error and abort;
  - a result struct typedef {onehot, cnt, flag}.
- One sub-module, au_lead_sign_enc: combinational detect plus encode (data, tc -> onehot, cnt, flag), instantiated in S1.
- Shifter and pipeline control live in the top.

## Test plan
- WIDTH=8, tc=1, data 0x1F -> onehot 0x20, cnt 2, norm 0x7C, flag 0, after exactly 2 cycles.
- tc=1, data 0xFF -> onehot 0x01, cnt 7, norm 0x80, flag 1; data 0x80 -> onehot 0x80, cnt 0, norm 0x80.
- tc=0, data 0x00 -> onehot 0x00, cnt 8, norm 0x00, flag 1; data 0x01 -> onehot 0x01, cnt 7, norm 0x80.
- Backpressure: stream tags 1..5 back-to-back with out_ready low for cycles 3-5. Required: in_ready drops once both stages are full, outputs stay stable while stalled, and all 5 results emerge in order with no loss.
- Reset asserted while 2 words are in flight: out_valid = 0 and outputs = 0 immediately, in_ready = 1, and the next word after release appears with latency 2.
- Macro undefined: same vectors give out_norm = 0 with onehot/cnt/flag unchanged.
